cam_sccb_config: RTL and testbench
==================================

// Module: cam_sccb_config
// PURPOSE
//  Power-up configuration sequencer for the camera sensor. Walks a register table and issues
//  SCCB 3-phase writes (device addr, reg addr, data) on sioc/siod. Sits beside the pixel capture
//  path: holds cfg_done low until the sensor is configured, so capture data is qualified only afterwards.
// PARAMETERS
//  CLK_HZ     25000000  clk_25 frequency in Hz
//  SCCB_HZ    100000    SCCB bit rate; quarter-bit tick Q = CLK_HZ/(4*SCCB_HZ) cycles (62 at defaults)
//  DEV_ADDR   8'h42     SCCB write address of the sensor
//  PWR_WAIT   250000    cycles to wait after start before the first transaction (10 ms)
//  DLY_WAIT   250000    cycles to wait on a delay marker entry (10 ms)
//  TABLE_AW   8         table address width
// PORTS
//  clk_25      in   1         system clock
//  reset_n     in   1         asynchronous active-low reset
//  start       in   1         single-cycle pulse: run the table from entry 0
//  table_addr  out  TABLE_AW  current table index
//  table_data  in   16        {reg_addr[15:8], value[7:0]}; combinational, valid in the same cycle as table_addr
//  sioc        out  1         SCCB clock (push-pull)
//  siod_oe     out  1         1 = drive SIOD low; 0 = release (external pull-up)
//  busy        out  1         sequence in progress
//  cfg_done    out  1         table completed; held until the next accepted start
// BEHAVIOUR
//  Reset values: sioc=1, siod_oe=0, busy=0, cfg_done=0, table_addr=0, state IDLE.
//  Reset asserted mid-transfer aborts at once to these values; there is no stop condition.
//  start is accepted only in IDLE or DONE; it clears cfg_done, sets table_addr=0 and busy=1 on the next edge.
//  start while busy is ignored.
//  States:
//   IDLE   -> PWR on start.
//   PWR    counts PWR_WAIT cycles -> FETCH.
//   FETCH  samples table_data:
//            16'hFFFF       -> DONE.
//            16'hFFF0       -> DELAY.
//            any other value -> START_C with latched shift bytes {DEV_ADDR, reg_addr, value}.
//   DELAY  counts DLY_WAIT cycles, table_addr+1 -> FETCH.
//   START_C: SIOD low while SIOC high for 1Q, then SIOC low for 1Q -> BITS.
//   BITS   27 bit slots = 3 bytes x (8 data bits MSB-first + 1 don't-care bit).
//          Each slot is 4Q:
//            Q0  sioc=0
//            Q1  sioc=0, SIOD updated
//            Q2  sioc=1
//            Q3  sioc=1
//          In the don't-care slot siod_oe=0 (released); the ACK level is not sampled.
//   STOP_C SIOC low + SIOD low for 1Q, then SIOC high for 1Q, then release SIOD.
//   GAP    bus idle 4Q; table_addr+1 -> FETCH.
//   DONE   busy=0, cfg_done=1, sioc=1, siod_oe=0.
//  SIOD changes only while sioc=0, except in the start and stop conditions.
//  One write takes 2Q + 108Q + 2Q + 4Q = 116Q.
//  Table end: if table_addr reaches 2^TABLE_AW-1 without a FFFF marker, that entry is processed and the
//  sequence then goes to DONE; the address never wraps.
//  Q counter and wait counters are free of overflow: each is sized to ceil(log2(max count + 1)).
//  busy=1 from the cycle after start acceptance until DONE entry; busy and cfg_done are never both 1.
// TESTING
//  1 Reset: hold reset_n=0 -> sioc=1, siod_oe=0, busy=0, cfg_done=0, table_addr=0; assert again mid-bit
//    -> same values on the next cycle (async).
//  2 Table {0x1280, FFFF}, small PWR_WAIT/Q: start -> bus monitor decodes one write 42/12/80; 27 SCL highs;
//    cfg_done=1; busy=0.
//  3 Protocol check over a 4-entry table: SIOD never changes while sioc=1 except start/stop;
//    write spacing equals 116Q + 1 fetch cycle.
//  4 Delay marker {0x1101, FFF0, 0x6B4A, FFFF}: gap between writes 1 and 2 = DLY_WAIT cycles + GAP;
//    no bus activity during the delay.
//  5 start pulsed during a transfer -> ignored, sequence unchanged; start after DONE -> cfg_done drops,
//    table rerun from entry 0.
//  6 TABLE_AW=2, no FFFF marker: 4 writes issued, table_addr stops at 3, cfg_done=1.

Source files
------------

// File: rtl/cam_sccb_config.sv
// Power-up SCCB configuration sequencer: walks a {reg_addr, value} table and issues
// 3-phase writes (device, register, value) to the camera sensor, then raises cfg_done.
module cam_sccb_config #(
    parameter int unsigned CLK_HZ   = 32'd25000000,
    parameter int unsigned SCCB_HZ  = 32'd100000,
    parameter logic [7:0]  DEV_ADDR = 8'h42,
    parameter int unsigned PWR_WAIT = 32'd250000,
    parameter int unsigned DLY_WAIT = 32'd250000,
    parameter int unsigned TABLE_AW = 32'd8
) (
    input  logic                clk_25,
    input  logic                reset_n,
    input  logic                start,
    output logic [TABLE_AW-1:0] table_addr,
    input  logic [15:0]         table_data,
    output logic                sioc,
    output logic                siod_oe,
    output logic                busy,
    output logic                cfg_done
);
    localparam int unsigned Q    = CLK_HZ / (32'd4 * SCCB_HZ);
    localparam int unsigned QW   = (Q > 32'd1) ? $clog2(Q) : 32'd1;
    localparam int unsigned WMAX = (PWR_WAIT > DLY_WAIT) ? PWR_WAIT : DLY_WAIT;
    localparam int unsigned WW   = (WMAX > 32'd1) ? $clog2(WMAX) : 32'd1;

    localparam logic [QW-1:0]       Q_LAST    = QW'(Q - 32'd1);
    localparam logic [WW-1:0]       PWR_LAST  = WW'(PWR_WAIT - 32'd1);
    localparam logic [WW-1:0]       DLY_LAST  = WW'(DLY_WAIT - 32'd1);
    localparam logic [TABLE_AW-1:0] ADDR_LAST = {TABLE_AW{1'b1}};

    typedef enum logic [3:0] {
        S_IDLE  = 4'd0,
        S_PWR   = 4'd1,
        S_FETCH = 4'd2,
        S_DELAY = 4'd3,
        S_START = 4'd4,
        S_BITS  = 4'd5,
        S_STOP  = 4'd6,
        S_GAP   = 4'd7,
        S_DONE  = 4'd8
    } state_t;

    state_t              state_q, state_d;
    logic [QW-1:0]       q_cnt_q, q_cnt_d;
    logic [6:0]          qn_q, qn_d;
    logic [WW-1:0]       wcnt_q, wcnt_d;
    logic [3:0]          bit_q, bit_d;
    logic [23:0]         sh_q, sh_d;
    logic [TABLE_AW-1:0] addr_q, addr_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;
    logic                sioc_q, sioc_d;
    logic                oe_q, oe_d;
    logic                q_tick;
    logic                last_entry;

    // State and output registers; reset aborts any transfer with the bus released.
    always_ff @(posedge clk_25 or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= S_IDLE;
            q_cnt_q <= {QW{1'b0}};
            qn_q    <= 7'd0;
            wcnt_q  <= {WW{1'b0}};
            bit_q   <= 4'd0;
            sh_q    <= 24'd0;
            addr_q  <= {TABLE_AW{1'b0}};
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            sioc_q  <= 1'b1;
            oe_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            q_cnt_q <= q_cnt_d;
            qn_q    <= qn_d;
            wcnt_q  <= wcnt_d;
            bit_q   <= bit_d;
            sh_q    <= sh_d;
            addr_q  <= addr_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            sioc_q  <= sioc_d;
            oe_q    <= oe_d;
        end
    end

    // Sequencer next state; bus levels are computed for the current quarter and registered.
    always_comb begin
        state_d    = state_q;
        q_cnt_d    = q_cnt_q;
        qn_d       = qn_q;
        wcnt_d     = wcnt_q;
        bit_d      = bit_q;
        sh_d       = sh_q;
        addr_d     = addr_q;
        busy_d     = busy_q;
        done_d     = done_q;
        sioc_d     = 1'b1;
        oe_d       = 1'b0;
        q_tick     = (q_cnt_q == Q_LAST);
        last_entry = (addr_q == ADDR_LAST);

        case (state_q)
            S_IDLE, S_DONE: begin
                if (start) begin
                    state_d = S_PWR;
                    addr_d  = {TABLE_AW{1'b0}};
                    busy_d  = 1'b1;
                    done_d  = 1'b0;
                    wcnt_d  = {WW{1'b0}};
                end else begin
                    state_d = state_q;
                end
            end
            S_PWR: begin
                if (wcnt_q == PWR_LAST) begin
                    state_d = S_FETCH;
                end else begin
                    wcnt_d = wcnt_q + {{(WW-1){1'b0}}, 1'b1};
                end
            end
            S_FETCH: begin
                if (table_data == 16'hFFFF) begin
                    state_d = S_DONE;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                end else if (table_data == 16'hFFF0) begin
                    state_d = S_DELAY;
                    wcnt_d  = {WW{1'b0}};
                end else begin
                    state_d = S_START;
                    sh_d    = {DEV_ADDR, table_data};
                    q_cnt_d = {QW{1'b0}};
                    qn_d    = 7'd0;
                    bit_d   = 4'd0;
                end
            end
            S_DELAY: begin
                if (wcnt_q != DLY_LAST) begin
                    wcnt_d = wcnt_q + {{(WW-1){1'b0}}, 1'b1};
                end else if (last_entry) begin
                    state_d = S_DONE;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                end else begin
                    state_d = S_FETCH;
                    addr_d  = addr_q + {{(TABLE_AW-1){1'b0}}, 1'b1};
                end
            end
            S_START: begin
                sioc_d  = ~qn_q[0];
                oe_d    = 1'b1;
                q_cnt_d = q_tick ? {QW{1'b0}} : q_cnt_q + {{(QW-1){1'b0}}, 1'b1};
                if (q_tick && qn_q[0]) begin
                    state_d = S_BITS;
                    qn_d    = 7'd0;
                end else if (q_tick) begin
                    qn_d = qn_q + 7'd1;
                end else begin
                    qn_d = qn_q;
                end
            end
            S_BITS: begin
                // Data moves only in the second quarter of a slot; the 9th slot releases SIOD.
                sioc_d  = qn_q[1];
                q_cnt_d = q_tick ? {QW{1'b0}} : q_cnt_q + {{(QW-1){1'b0}}, 1'b1};
                if (qn_q[1:0] == 2'd1) begin
                    oe_d = (bit_q == 4'd8) ? 1'b0 : ~sh_q[23];
                end else begin
                    oe_d = oe_q;
                end
                if (q_tick && (qn_q[1:0] == 2'd3)) begin
                    if (bit_q == 4'd8) begin
                        bit_d = 4'd0;
                    end else begin
                        bit_d = bit_q + 4'd1;
                        sh_d  = {sh_q[22:0], 1'b0};
                    end
                end else begin
                    bit_d = bit_q;
                end
                if (q_tick && (qn_q == 7'd107)) begin
                    state_d = S_STOP;
                    qn_d    = 7'd0;
                end else if (q_tick) begin
                    qn_d = qn_q + 7'd1;
                end else begin
                    qn_d = qn_q;
                end
            end
            S_STOP: begin
                sioc_d  = qn_q[0];
                oe_d    = 1'b1;
                q_cnt_d = q_tick ? {QW{1'b0}} : q_cnt_q + {{(QW-1){1'b0}}, 1'b1};
                if (q_tick && qn_q[0]) begin
                    state_d = S_GAP;
                    qn_d    = 7'd0;
                end else if (q_tick) begin
                    qn_d = qn_q + 7'd1;
                end else begin
                    qn_d = qn_q;
                end
            end
            S_GAP: begin
                q_cnt_d = q_tick ? {QW{1'b0}} : q_cnt_q + {{(QW-1){1'b0}}, 1'b1};
                if (q_tick && (qn_q == 7'd3)) begin
                    qn_d = 7'd0;
                    if (last_entry) begin
                        state_d = S_DONE;
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                    end else begin
                        state_d = S_FETCH;
                        addr_d  = addr_q + {{(TABLE_AW-1){1'b0}}, 1'b1};
                    end
                end else if (q_tick) begin
                    qn_d = qn_q + 7'd1;
                end else begin
                    qn_d = qn_q;
                end
            end
            default: begin
                state_d = S_IDLE;
                busy_d  = 1'b0;
                done_d  = 1'b0;
            end
        endcase
    end

    assign table_addr = addr_q;
    assign sioc       = sioc_q;
    assign siod_oe    = oe_q;
    assign busy       = busy_q;
    assign cfg_done   = done_q;

endmodule

// File: tb/tb_cam_sccb_config.sv
// Self-checking bench for cam_sccb_config: a bus decoder compares decoded SCCB writes and their
// timing against a table-walk model, with directed and randomized tables.
module tb_cam_sccb_config;
    localparam int CLK_HZ    = 1200;
    localparam int SCCB_HZ   = 100;
    localparam int PW        = 20;
    localparam int DW        = 50;
    localparam int Q         = CLK_HZ / (4 * SCCB_HZ);
    localparam int WRITE_CYC = 116 * Q + 1;

    typedef struct packed {
        logic [15:0] data;
        logic [7:0]  ndly;
    } wr_t;

    logic        clk_25  = 1'b0;
    logic        reset_n = 1'b1;
    logic        start   = 1'b0;
    logic [1:0]  table_addr;
    logic [15:0] table_data;
    logic        sioc, siod_oe, busy, cfg_done;
    logic [15:0] tbl [4];

    int   n_checks = 0;
    int   n_pass   = 0;
    int   cyc      = 0;
    wr_t  exp_q[$];
    int   exp_end_addr;
    logic first_w  = 1'b0;
    int   acc_cyc  = 0;
    int   n_writes = 0;
    logic [23:0] last_wr = 24'd0;
    int   last_spacing = 0;

    logic        prev_sioc, prev_oe, in_frame;
    int          rises, last_start, lat, lo;
    logic [31:0] bits;
    logic [7:0]  dev, rg, val;
    wr_t         e;

    assign table_data = tbl[table_addr];

    always #5 clk_25 = ~clk_25;
    always @(posedge clk_25) cyc <= cyc + 1;

    cam_sccb_config #(
        .CLK_HZ(CLK_HZ), .SCCB_HZ(SCCB_HZ), .DEV_ADDR(8'h42),
        .PWR_WAIT(PW), .DLY_WAIT(DW), .TABLE_AW(2)
    ) dut (
        .clk_25(clk_25), .reset_n(reset_n), .start(start),
        .table_addr(table_addr), .table_data(table_data),
        .sioc(sioc), .siod_oe(siod_oe), .busy(busy), .cfg_done(cfg_done)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: actual=%0h required=%0h (t=%0t)", name, act, exp, $time);
    endtask

    // Bus decoder and per-cycle comparison against the model
    always @(negedge clk_25) begin
        if (!reset_n) begin
            prev_sioc = 1'b1;
            prev_oe   = 1'b0;
            in_frame  = 1'b0;
            rises     = 0;
        end else begin
            chk("busy_cfg_done_exclusive", {31'd0, busy & cfg_done}, 32'd0);
            if (exp_q.size() != 0) chk("busy_while_pending", {30'd0, busy, cfg_done}, 32'd2);
            if (prev_sioc && sioc && (prev_oe != siod_oe)) begin
                if (siod_oe) begin
                    chk("start_outside_frame", {31'd0, in_frame}, 32'd0);
                    in_frame = 1'b1;
                    rises    = 0;
                    bits     = 32'd0;
                    if (first_w && exp_q.size() != 0) begin
                        lat = cyc - acc_cyc;
                        lo  = PW + 1 + int'(exp_q[0].ndly) * (DW + 1);
                        chk("first_write_latency", {31'd0, (lat >= lo) && (lat <= lo + 2)}, 32'd1);
                        first_w = 1'b0;
                    end else if (exp_q.size() != 0) begin
                        last_spacing = cyc - last_start;
                        chk("write_spacing", last_spacing, WRITE_CYC + int'(exp_q[0].ndly) * (DW + 1));
                    end
                    last_start = cyc;
                end else begin
                    chk("stop_inside_frame", {31'd0, in_frame}, 32'd1);
                    in_frame = 1'b0;
                    chk("scl_rises_27_plus_stop", rises, 28);
                    for (int k = 0; k < 8; k++) begin
                        dev[7-k] = bits[k];
                        rg[7-k]  = bits[9+k];
                        val[7-k] = bits[18+k];
                    end
                    chk("ack_slots_released", {29'd0, bits[8], bits[17], bits[26]}, 32'd7);
                    chk("write_was_expected", {31'd0, exp_q.size() != 0}, 32'd1);
                    if (exp_q.size() != 0) begin
                        e = exp_q.pop_front();
                        chk("write_bytes", {8'd0, dev, rg, val}, {8'd0, 8'h42, e.data});
                        n_writes++;
                        last_wr = {dev, rg, val};
                    end
                end
            end else if (sioc && !prev_sioc && in_frame) begin
                if (rises < 32) bits[rises] = ~siod_oe;
                rises++;
            end
            if (!in_frame) chk("bus_idle", {30'd0, sioc, siod_oe}, 32'd2);
            prev_sioc = sioc;
            prev_oe   = siod_oe;
        end
    end

    task automatic load_model(input logic [15:0] t0, t1, t2, t3);
        logic [15:0] t [4];
        logic        stop;
        logic [7:0]  nd;
        wr_t         w;
        t[0] = t0; t[1] = t1; t[2] = t2; t[3] = t3;
        for (int i = 0; i < 4; i++) tbl[i] = t[i];
        stop = 1'b0;
        nd   = 8'd0;
        exp_end_addr = 3;
        exp_q.delete();
        for (int i = 0; i < 4; i++) begin
            if (!stop) begin
                if (t[i] == 16'hFFFF) begin
                    stop = 1'b1;
                    exp_end_addr = i;
                end else if (t[i] == 16'hFFF0) begin
                    nd = nd + 8'd1;
                end else begin
                    w.data = t[i];
                    w.ndly = nd;
                    exp_q.push_back(w);
                    nd = 8'd0;
                end
            end
        end
    endtask

    task automatic pulse_start();
        @(negedge clk_25);
        start = 1'b1;
        @(posedge clk_25);
        #1;
        start = 1'b0;
    endtask

    task automatic run_table(input logic [15:0] t0, t1, t2, t3, input bit mid_start);
        int w;
        wr_t saved[$];
        load_model(t0, t1, t2, t3);
        saved = exp_q;
        exp_q.delete();
        pulse_start();
        exp_q    = saved;
        acc_cyc  = cyc;
        n_writes = 0;
        first_w  = 1'b1;
        chk("accept_busy_cfg_done", {30'd0, busy, cfg_done}, 32'd2);
        chk("accept_table_addr", {30'd0, table_addr}, 32'd0);
        if (mid_start) begin
            repeat (PW + 150) @(negedge clk_25);
            pulse_start();
        end
        w = 0;
        while (!cfg_done && w < 4000) begin
            @(negedge clk_25);
            w++;
        end
        chk("done_reached", {31'd0, cfg_done}, 32'd1);
        chk("busy_low_at_done", {31'd0, busy}, 32'd0);
        chk("all_writes_seen", exp_q.size(), 32'd0);
        chk("end_table_addr", {30'd0, table_addr}, exp_end_addr);
        repeat (5) @(negedge clk_25);
    endtask

    function automatic logic [15:0] rnd_entry();
        logic [15:0] d;
        case ($urandom_range(0, 9))
            0:       d = 16'hFFFF;
            1:       d = 16'hFFF0;
            default: begin
                d = 16'($urandom);
                if (d == 16'hFFFF || d == 16'hFFF0) d = d ^ 16'h0001;
            end
        endcase
        return d;
    endfunction

    initial begin
        for (int i = 0; i < 4; i++) tbl[i] = 16'hFFFF;
        #2 reset_n = 1'b0;
        repeat (3) @(negedge clk_25);
        chk("reset_values", {26'd0, sioc, siod_oe, busy, cfg_done, table_addr}, 32'h20);
        reset_n = 1'b1;
        repeat (3) @(negedge clk_25);
        chk("idle_after_reset", {26'd0, sioc, siod_oe, busy, cfg_done, table_addr}, 32'h20);

        run_table(16'h1280, 16'hFFFF, 16'hFFFF, 16'hFFFF, 1'b0);
        chk("single_write_bytes", {8'd0, last_wr}, 32'h00421280);
        chk("single_write_count", n_writes, 32'd1);

        run_table(16'h1111, 16'h2222, 16'h3333, 16'hFFFF, 1'b0);
        chk("back_to_back_spacing", last_spacing, 32'd349);
        chk("three_write_count", n_writes, 32'd3);

        run_table(16'h1101, 16'hFFF0, 16'h6B4A, 16'hFFFF, 1'b0);
        chk("delay_marker_spacing", last_spacing, 32'd400);
        chk("delay_last_bytes", {8'd0, last_wr}, 32'h00426B4A);

        run_table(16'hA0B1, 16'hC2D3, 16'hFFFF, 16'hFFFF, 1'b1);
        chk("start_while_busy_ignored", n_writes, 32'd2);

        run_table(16'h0102, 16'h0304, 16'h0506, 16'h0708, 1'b0);
        chk("no_marker_write_count", n_writes, 32'd4);
        chk("no_marker_addr_stops", {30'd0, table_addr}, 32'd3);

        for (int r = 0; r < 10; r++)
            run_table(rnd_entry(), rnd_entry(), rnd_entry(), rnd_entry(), r[0]);

        load_model(16'h5A5A, 16'hFFFF, 16'hFFFF, 16'hFFFF);
        exp_q.delete();
        pulse_start();
        repeat (PW + 100) @(negedge clk_25);
        #1;
        chk("in_frame_before_reset", {31'd0, in_frame}, 32'd1);
        @(posedge clk_25);
        #2 reset_n = 1'b0;
        #1;
        chk("async_reset_mid_bit", {26'd0, sioc, siod_oe, busy, cfg_done, table_addr}, 32'h20);
        first_w = 1'b0;
        repeat (2) @(negedge clk_25);
        reset_n = 1'b1;
        repeat (3) @(negedge clk_25);

        run_table(16'h3A5C, 16'hFFFF, 16'hFFFF, 16'hFFFF, 1'b0);
        chk("recovery_bytes", {8'd0, last_wr}, 32'h00423A5C);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
